// File: rtl/blk_699c1a.sv
// Avalon-ST packet-to-byte encoder: serialises each beat into channel, SOP, EOP and
// data bytes using the 0x7A-0x7D escape protocol understood by the bytes-to-packets side.
module blk_699c1a #(
    parameter int CHANNEL_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     in_ready,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic [CHANNEL_WIDTH-1:0] in_channel,
    input  logic                     in_startofpacket,
    input  logic                     in_endofpacket,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data
);

    typedef enum logic [2:0] {
        IDLE,
        CHAN_IND,
        CHAN_ESC,
        CHAN_BYTE,
        SOP,
        EOP,
        DATA_ESC,
        DATA
    } state_t;

    localparam logic [7:0] SOP_CHAR  = 8'h7A;
    localparam logic [7:0] EOP_CHAR  = 8'h7B;
    localparam logic [7:0] CHAN_CHAR = 8'h7C;
    localparam logic [7:0] ESC_CHAR  = 8'h7D;
    localparam logic [7:0] ESC_XOR   = 8'h20;

    state_t     r_state;
    logic [7:0] r_data;
    logic [7:0] r_chan;
    logic       r_sop;
    logic       r_eop;
    logic [7:0] r_lastChan;
    logic       r_chanSent;

    logic [7:0] w_inChan;
    logic       w_needChan;
    logic       w_inFire;
    logic       w_outFire;
    state_t     w_firstState;

    function automatic logic isSpecial(input logic [7:0] b);
        return (b >= SOP_CHAR) && (b <= ESC_CHAR);
    endfunction

    function automatic state_t dataState(input logic [7:0] d);
        return isSpecial(d) ? DATA_ESC : DATA;
    endfunction

    // State that follows the channel bytes (or the first state when no channel is due).
    function automatic state_t afterChan(input logic sop, input logic eop, input logic [7:0] d);
        if (sop)
            return SOP;
        else if (eop)
            return EOP;
        else
            return dataState(d);
    endfunction

    assign w_inChan     = 8'(in_channel);
    assign w_needChan   = !r_chanSent || (w_inChan != r_lastChan);
    assign w_firstState = w_needChan ? CHAN_IND
                                     : afterChan(in_startofpacket, in_endofpacket, in_data);

    assign out_valid = (r_state != IDLE);
    assign in_ready  = !reset && ((r_state == IDLE) || ((r_state == DATA) && out_ready));
    assign w_inFire  = in_valid && in_ready;
    assign w_outFire = out_valid && out_ready;

    // A new beat can only be taken in IDLE or as DATA drains, so loading takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_data     <= 8'h00;
            r_chan     <= 8'h00;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
            r_lastChan <= 8'h00;
            r_chanSent <= 1'b0;
        end else if (w_inFire) begin
            r_data  <= in_data;
            r_chan  <= w_inChan;
            r_sop   <= in_startofpacket;
            r_eop   <= in_endofpacket;
            r_state <= w_firstState;
            if (w_needChan) begin
                r_lastChan <= w_inChan;
                r_chanSent <= 1'b1;
            end
        end else if (w_outFire) begin
            case (r_state)
                CHAN_IND:  r_state <= isSpecial(r_chan) ? CHAN_ESC : CHAN_BYTE;
                CHAN_ESC:  r_state <= CHAN_BYTE;
                CHAN_BYTE: r_state <= afterChan(r_sop, r_eop, r_data);
                SOP:       r_state <= r_eop ? EOP : dataState(r_data);
                EOP:       r_state <= dataState(r_data);
                DATA_ESC:  r_state <= DATA;
                DATA:      r_state <= IDLE;
                default:   r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        out_data = 8'h00;
        case (r_state)
            CHAN_IND:  out_data = CHAN_CHAR;
            CHAN_ESC:  out_data = ESC_CHAR;
            CHAN_BYTE: out_data = isSpecial(r_chan) ? (r_chan ^ ESC_XOR) : r_chan;
            SOP:       out_data = SOP_CHAR;
            EOP:       out_data = EOP_CHAR;
            DATA_ESC:  out_data = ESC_CHAR;
            DATA:      out_data = isSpecial(r_data) ? (r_data ^ ESC_XOR) : r_data;
            default:   out_data = 8'h00;
        endcase
    end

endmodule

// File: doc/blk_699c1a.md
# qsys_nios2_ddr3_mem_if_ddr3_emif_0_dmaster_p2b_converter

Encodes an Avalon-ST packet stream with channel, SOP and EOP into a flat byte stream using the escape-character protocol that the debug-master byte-to-packet path decodes. It sits on the response side of the EMIF debug master, in front of the byte transport. It inserts channel, SOP, EOP and escape bytes so the far-end bytes-to-packets converter can rebuild each beat. It holds one input beat and emits its encoded bytes one per cycle under backpressure.

## Interface
- CHANNEL_WIDTH, 8: width of in_channel, range 1-8; zero-extended to 8 bits for encoding.
- clk  in  1  sole clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- in_ready  out  1  sink ready; a beat transfers on in_valid && in_ready.
- in_valid  in  1  beat valid.
- in_data  in  8  payload byte.
- in_channel  in  CHANNEL_WIDTH  channel of the beat.
- in_startofpacket  in  1  first beat of a packet.
- in_endofpacket  in  1  last beat of a packet.
- out_ready  in  1  downstream ready.
- out_valid  out  1  encoded byte valid.
- out_data  out  8  encoded byte.

## Operation
- Special bytes:
  - 0x7A: SOP.
  - 0x7B: EOP.
  - 0x7C: channel indicator.
  - 0x7D: escape.
  - An escaped byte is emitted as 0x7D followed by (byte XOR 0x20).
- Per-beat emission order. Inapplicable items are skipped.
  1. CHAN: 0x7C, then the channel byte, escaped if it falls in 0x7A-0x7D. Emitted when no channel has been sent since reset, or when the channel differs from last_channel. SOP does not force CHAN.
  2. SOP: 0x7A if in_startofpacket.
  3. EOP: 0x7B if in_endofpacket.
  4. DATA: the data byte, escaped if it falls in 0x7A-0x7D.
- Registers:
  - Beat holding register: data, channel, sop, eop.
  - last_channel (8 bits) and chan_sent flag. Both are updated at beat load whenever CHAN is scheduled.
- FSM states: IDLE, CHAN_IND, CHAN_ESC, CHAN_BYTE, SOP, EOP, DATA_ESC, DATA.
  - The state names the byte currently presented on out_data.
  - On an accepted output byte (out_valid && out_ready), advance to the next applicable state.
  - After DATA is accepted, go to IDLE. If a new beat is accepted in the same cycle, load it and go directly to its first applicable state.
  - IDLE with a beat accepted: load the beat, go to its first applicable state.
- out_valid = (state != IDLE).
- out_data is a function of state and held registers only. There is no combinational path from any input to out_valid or out_data.
- in_ready = !reset && (state == IDLE || (state == DATA && out_ready)).
- Channel change without SOP (e.g. mid-packet) still emits CHAN before the data byte.

## Timing
- Reset values:
  - state = IDLE, so out_valid = 0.
  - out_data = 0x00.
  - in_ready = 0 while reset is asserted.
  - chan_sent = 0, last_channel = 0, holding register = 0.
- Latency: a beat accepted at edge N presents its first byte after edge N.
- Throughput with out_ready held high:
  - One byte per cycle.
  - An unescaped mid-packet beat with an unchanged channel yields one byte per beat with no bubbles.
  - Worst case is 7 bytes per beat: CHAN with escaped channel (3), SOP, EOP, escaped data (2).
- Backpressure: while out_valid && !out_ready, out_data and state hold and in_ready = 0.
- Reset mid-sequence: outputs return to reset values asynchronously and the held beat is discarded. The next beat re-emits CHAN because chan_sent = 0.
- in_valid may drop between beats. No input-side requirement beyond the valid/ready transfer rule.

## Test plan
- Reset, then one beat {data 0x55, ch 0, sop, eop} -> bytes 7C 00 7A 7B 55 on 5 consecutive cycles; in_ready low until 55 is accepted.
- Follow-on beat {data 0x7B, ch 0, no sop/eop} -> 7D 5B (no channel resent).
- Beat {data 0x01, ch 0x7D, sop} -> 7C 7D 5D 7A 01; a subsequent beat on ch 0x03 mid-packet {data 0x02} -> 7C 03 02.
- Four mid-packet beats 0x10-0x13, same channel, out_ready = 1 -> 10 11 12 13 on 4 consecutive cycles; in_ready stays high throughout.
- Beat data 0x7A; hold out_ready low 3 cycles while 7D is presented -> out_data stays 7D and in_ready = 0 for those cycles; then 7D 5A drain normally.
- Assert reset after 7C has been accepted -> out_valid 0 immediately; after release, beat {ch 0, data 0x20} -> 7C 00 20.
